// File: rtl/ascon_pkg.sv
// Shared types, constants and helpers for the iterative ASCON permutation.
package ascon_pkg;

  typedef logic [63:0] word_t;
  // Element 0 (x0) sits in the most significant 64 bits of the packed state.
  typedef word_t [0:4] state_t;

  localparam int unsigned ROT0A = 19;
  localparam int unsigned ROT0B = 28;
  localparam int unsigned ROT1A = 61;
  localparam int unsigned ROT1B = 39;
  localparam int unsigned ROT2A = 1;
  localparam int unsigned ROT2B = 6;
  localparam int unsigned ROT3A = 10;
  localparam int unsigned ROT3B = 17;
  localparam int unsigned ROT4A = 7;
  localparam int unsigned ROT4B = 41;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } fsm_e;

  // Mode 11 is reserved and behaves like mode 00.
  function automatic logic [3:0] rounds_dec(input logic [1:0] mode);
    unique case (mode)
      2'b01:   return 4'd8;
      2'b10:   return 4'd6;
      default: return 4'd12;
    endcase
  endfunction

  function automatic logic [7:0] round_const(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  function automatic word_t rotr(input word_t w, input int unsigned n);
    return (w >> n) | (w << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, bitsliced S-box, linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] rc_idx_i,
  output state_t     state_o
);

  state_t x;
  state_t t;

  // Full round evaluated on the five 64-bit words in parallel.
  always_comb begin
    x = state_i;
    x[2][7:0] = x[2][7:0] ^ round_const(rc_idx_i);
    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    for (int j = 0; j < 5; j++) begin
      t[j] = ~x[j] & x[(j + 1) % 5];
    end
    for (int j = 0; j < 5; j++) begin
      x[j] = x[j] ^ t[(j + 1) % 5];
    end
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];
    state_o[0] = x[0] ^ rotr(x[0], ROT0A) ^ rotr(x[0], ROT0B);
    state_o[1] = x[1] ^ rotr(x[1], ROT1A) ^ rotr(x[1], ROT1B);
    state_o[2] = x[2] ^ rotr(x[2], ROT2A) ^ rotr(x[2], ROT2B);
    state_o[3] = x[3] ^ rotr(x[3], ROT3A) ^ rotr(x[3], ROT3B);
    state_o[4] = x[4] ^ rotr(x[4], ROT4A) ^ rotr(x[4], ROT4B);
  end

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative ASCON permutation (p^12 / p^8 / p^6), UNROLL rounds per clock.
// Optional build macro ASCON_PERM_ZEROIZE_EN: clears the state on the output
// handshake and hides out_state whenever out_valid is low.
module ascon_perm_iter
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         busy
);

  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("ascon_perm_iter: UNROLL must be 1 or 2");
  end

  localparam logic [3:0] UnrollStep = 4'(UNROLL);

  fsm_e       fsm_q, fsm_d;
  logic [3:0] rc_idx_q, rc_idx_d;
  state_t     state_q, state_d;
  logic [3:0] rc_next;
  state_t     chain [UNROLL+1];

  assign chain[0] = state_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    ascon_round u_round (
      .state_i  (chain[k]),
      .rc_idx_i (rc_idx_q + 4'(k)),
      .state_o  (chain[k+1])
    );
  end

  assign rc_next = rc_idx_q + UnrollStep;

  // Next-state logic: load on accept, iterate in RUN, hold until consumed.
  always_comb begin
    fsm_d    = fsm_q;
    rc_idx_d = rc_idx_q;
    state_d  = state_q;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid) begin
          state_d  = state_t'(in_state);
          rc_idx_d = 4'd12 - rounds_dec(in_mode);
          fsm_d    = StRun;
        end
      end
      StRun: begin
        state_d  = chain[UNROLL];
        rc_idx_d = rc_next;
        if (rc_next == 4'd12) begin
          fsm_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          fsm_d = StIdle;
`ifdef ASCON_PERM_ZEROIZE_EN
          state_d = '0;
`endif
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  // State registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= StIdle;
      rc_idx_q <= 4'd0;
      state_q  <= '0;
    end else begin
      fsm_q    <= fsm_d;
      rc_idx_q <= rc_idx_d;
      state_q  <= state_d;
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    in_ready  = (fsm_q == StIdle);
    out_valid = (fsm_q == StDone);
    busy      = (fsm_q != StIdle);
`ifdef ASCON_PERM_ZEROIZE_EN
    out_state = out_valid ? 320'(state_q) : '0;
`else
    out_state = 320'(state_q);
`endif
  end

endmodule
